therm_sampler: RTL and testbench
================================

THERM_SAMPLER -- requirements
Module: therm_sampler

Interface
REQ-001 Parameter: AVG_LOG2, default 3, log2 of the number of samples averaged per result (1..4).
REQ-002 Parameter: TIMEOUT, default 50000, number of clock cycles without a sensor clock edge before a fault is declared.
REQ-003 Port: clock  in  1  system clock; every flop is clocked on its rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: clkin  in  1  sensor strobe, asynchronous to clock; data is valid at its rising edge.
REQ-006 Port: in0..in7  in  1 each  sensor data bits, asynchronous to clock; in0 is the LSB and in7 is the MSB.
REQ-007 Port: rd_ack  in  1  processor acknowledge; a 1-cycle pulse consumes the current result.
REQ-008 Port: temp_word  out  32  latest averaged temperature, formatted as {24'b0, avg[7:0]}.
REQ-009 Port: temp_valid  out  1  temp_word holds an unconsumed result.
REQ-010 Port: overrun  out  1  sticky flag: a result was overwritten before it was acknowledged.
REQ-011 Port: sensor_fault  out  1  clkin has stalled for at least TIMEOUT cycles.

Function
REQ-012 clkin and in0..in7 shall each pass through a 2-flop synchronizer (s1, s2), and clkin shall have a third flop (s3).
REQ-013 A sample strobe shall be asserted in any cycle where clkin_s2=1 and clkin_s3=0; the captured byte is {in7..in0}_s2 in that same cycle.
REQ-014 The FSM shall have two states, WAIT and ACCUM; WAIT is the reset state.
REQ-015 WAIT->ACCUM shall occur on the first strobe; that strobe counts as sample 1.
REQ-016 In ACCUM, each strobe shall add the byte to an accumulator of width 8+AVG_LOG2 bits, which cannot overflow, and shall increment a sample counter.
REQ-017 On the strobe that completes 2^AVG_LOG2 samples, at the next clock edge: temp_word <= {24'b0, (acc+byte)>>AVG_LOG2} (truncating), temp_valid <= 1, and the accumulator and counter clear to 0; the FSM stays in ACCUM.
REQ-018 The latency from the completing strobe to temp_valid=1 shall be exactly 1 clock.
REQ-019 rd_ack while temp_valid=1 shall clear temp_valid at the next edge; temp_word shall hold its value.
REQ-020 rd_ack while temp_valid=0 shall be ignored.
REQ-021 If a completion occurs in the same cycle as rd_ack: temp_word updates, temp_valid stays 1, and overrun is unchanged.
REQ-022 If a completion occurs while temp_valid=1 with no rd_ack: temp_word is overwritten, temp_valid stays 1, and overrun <= 1.
REQ-023 overrun shall clear only on reset.
REQ-024 The watchdog counter shall clear on every strobe and otherwise increment, saturating at TIMEOUT.
REQ-025 When the watchdog counter reaches TIMEOUT: sensor_fault <= 1, temp_valid <= 0, the accumulator and counter clear, and the FSM goes to WAIT; temp_word is retained.
REQ-026 sensor_fault shall clear on the next strobe, which is also taken as sample 1 of a fresh batch through the WAIT->ACCUM transition.
REQ-027 If a strobe and the timeout coincide, the strobe shall take priority and no fault is raised.
REQ-028 clkin falling edges and data changes between strobes shall have no effect.

Reset
REQ-029 When reset is asserted, all of the following shall be 0 asynchronously: temp_word, temp_valid, overrun, sensor_fault, the synchronizers, accumulator, sample counter and watchdog; the FSM shall be in WAIT.
REQ-030 Reset asserted mid-batch shall discard the partial accumulation; after release, the first strobe starts a new batch.
REQ-031 Reset release shall not produce a strobe, even if clkin=1 at release.

Verification
REQ-032 A bench shall cover the following directed scenarios:
- Steady average: 8 strobes with byte 0x40 -> temp_word=0x00000040 and temp_valid=1 exactly 1 clock after the 8th strobe.
- Truncation: bytes 0x01,0x02,...,0x08 -> sum 36 -> temp_word=0x00000004.
- Overrun: 16 strobes of 0xFF with no rd_ack -> temp_word=0x000000FF, temp_valid=1, overrun=1; then rd_ack -> temp_valid=0 and overrun stays 1.
- Ack/complete collision: rd_ack pulsed in the completion cycle -> temp_valid remains 1, temp_word is the new value, overrun=0.
- Timeout: with TIMEOUT=100, hold clkin low for 100 cycles after 3 strobes -> sensor_fault=1 and temp_valid=0; then 8 strobes of 0x20 -> sensor_fault=0 after the first of them and temp_word=0x00000020.
- Mid-batch reset: 5 strobes of 0x80, reset pulse, then 8 strobes of 0x10 -> temp_word=0x00000010 and overrun=0.

Source files
------------

// File: rtl/therm_sampler.sv
// therm_sampler: synchronises an 8-bit sensor bus, averages 2^AVG_LOG2 samples per result and flags overruns and stalled sensor clocks
module therm_sampler #(
  parameter int AVG_LOG2 = 3,
  parameter int TIMEOUT = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clkin,
  input  logic        in0,
  input  logic        in1,
  input  logic        in2,
  input  logic        in3,
  input  logic        in4,
  input  logic        in5,
  input  logic        in6,
  input  logic        in7,
  input  logic        rd_ack,
  output logic [31:0] temp_word,
  output logic        temp_valid,
  output logic        overrun,
  output logic        sensor_fault
);
  localparam int AW = 8 + AVG_LOG2;
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic {WAIT, ACCUM} state_t;
  state_t state, state_n;
  logic [2:0] clk_s, warm;
  logic [7:0] d_s1, d_s2;
  logic [AW-1:0] acc, acc_n, sum;
  logic [AVG_LOG2-1:0] cnt, cnt_n;
  logic [WW-1:0] wd;
  logic strobe, tout, done;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      clk_s <= '0;
      warm <= '0;
      d_s1 <= '0;
      d_s2 <= '0;
    end else begin
      clk_s <= {clk_s[1:0], clkin};
      warm <= {warm[1:0], 1'b1};
      d_s1 <= {in7, in6, in5, in4, in3, in2, in1, in0};
      d_s2 <= d_s1;
    end
  // warm keeps the reset-forced zeros in the clkin pipe from looking like a rising edge
  assign strobe = clk_s[1] & ~clk_s[2] & warm[2];
  assign tout = ~strobe & (wd == WW'(TIMEOUT));
  assign sum = acc + AW'(d_s2);
  assign done = strobe & (state == ACCUM) & (cnt == '1);
  always_comb begin
    state_n = state;
    acc_n = acc;
    cnt_n = cnt;
    if (tout) begin
      state_n = WAIT;
      acc_n = '0;
      cnt_n = '0;
    end else if (strobe) begin
      state_n = ACCUM;
      acc_n = done ? '0 : sum;
      cnt_n = cnt + 1'b1;
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= WAIT;
      acc <= '0;
      cnt <= '0;
      wd <= '0;
      temp_word <= '0;
      temp_valid <= 1'b0;
      overrun <= 1'b0;
      sensor_fault <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
      wd <= strobe ? '0 : (wd == WW'(TIMEOUT) ? wd : wd + 1'b1);
      if (done) temp_word <= {24'b0, sum[AW-1:AVG_LOG2]};
      temp_valid <= ~tout & (done | (temp_valid & ~rd_ack));
      overrun <= overrun | (done & temp_valid & ~rd_ack);
      sensor_fault <= ~strobe & (tout | sensor_fault);
    end
endmodule

// File: tb/tb_therm_sampler.sv
// tb_therm_sampler: directed scenarios checked every cycle against a behavioural averaging model
module tb_therm_sampler;
  localparam int L = 3;
  localparam int TO = 100;
  localparam int N = 1 << L;
  logic clock = 0, reset = 1, clkin = 0, rd_ack = 0;
  logic [7:0] din = 0;
  logic [31:0] temp_word;
  logic temp_valid, overrun, sensor_fault;
  int checks = 0, errors = 0;
  bit h_c [3] = '{0, 0, 0};
  logic [7:0] h_d [3] = '{0, 0, 0};
  int posts = 0, m_sum = 0, m_n = 0, m_idle = 0;
  logic [31:0] m_word = 0;
  bit m_valid = 0, m_ovr = 0, m_fault = 0, m_stb;
  logic [7:0] m_b;

  always #5 clock = ~clock;

  therm_sampler #(.AVG_LOG2(L), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .clkin(clkin),
    .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
    .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
    .rd_ack(rd_ack), .temp_word(temp_word), .temp_valid(temp_valid),
    .overrun(overrun), .sensor_fault(sensor_fault)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // a strobe is a 0->1 step in the clkin samples taken two and three edges back
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      posts = 0; m_sum = 0; m_n = 0; m_idle = 0;
      m_word = 0; m_valid = 0; m_ovr = 0; m_fault = 0;
    end else begin
      m_stb = posts >= 3 && h_c[1] && !h_c[2];
      m_b = h_d[1];
      if (m_stb) begin
        m_fault = 0;
        m_idle = 0;
        m_sum += m_b;
        m_n++;
        if (m_n == N) begin
          if (m_valid && !rd_ack) m_ovr = 1;
          m_word = m_sum / N;
          m_valid = 1;
          m_sum = 0;
          m_n = 0;
        end else if (rd_ack) m_valid = 0;
      end else if (m_idle == TO) begin
        m_fault = 1; m_valid = 0; m_sum = 0; m_n = 0;
      end else begin
        m_idle++;
        if (rd_ack) m_valid = 0;
      end
      h_c[2] = h_c[1]; h_c[1] = h_c[0]; h_c[0] = clkin;
      h_d[2] = h_d[1]; h_d[1] = h_d[0]; h_d[0] = din;
      posts++;
    end
  end

  always @(negedge clock) begin
    chk("model temp_word", temp_word, m_word);
    chk("model temp_valid", {31'b0, temp_valid}, {31'b0, m_valid});
    chk("model overrun", {31'b0, overrun}, {31'b0, m_ovr});
    chk("model sensor_fault", {31'b0, sensor_fault}, {31'b0, m_fault});
  end

  task automatic send(input logic [7:0] b, input int ack_at = 0);
    din = b;
    clkin = 0;
    repeat (4) @(negedge clock);
    clkin = 1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      rd_ack = (i == ack_at);
    end
    rd_ack = 0;
  endtask

  task automatic ack_pulse();
    @(negedge clock) rd_ack = 1;
    @(negedge clock) rd_ack = 0;
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(posedge clock); #2 reset = 1;
    repeat (2) @(posedge clock);
    #2 reset = 0;
    @(negedge clock);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("reset word", temp_word, 0);
    chk("reset flags", {28'b0, temp_valid, overrun, sensor_fault, 1'b0}, 0);
    @(posedge clock); #2 reset = 0;
    @(negedge clock);
    repeat (8) send(8'h40);
    chk("steady word", temp_word, 32'h40);
    chk("steady valid", {31'b0, temp_valid}, 1);
    ack_pulse();
    chk("steady ack valid", {31'b0, temp_valid}, 0);
    chk("steady ack word", temp_word, 32'h40);
    do_reset();
    for (int i = 1; i <= 8; i++) send(8'(i));
    chk("trunc word", temp_word, 32'h4);
    do_reset();
    repeat (16) send(8'hFF);
    chk("ovr word", temp_word, 32'hFF);
    chk("ovr valid", {31'b0, temp_valid}, 1);
    chk("ovr flag", {31'b0, overrun}, 1);
    ack_pulse();
    chk("ovr ack valid", {31'b0, temp_valid}, 0);
    chk("ovr sticky", {31'b0, overrun}, 1);
    do_reset();
    repeat (8) send(8'h10);
    repeat (7) send(8'h30);
    send(8'h30, 2);
    chk("collide valid", {31'b0, temp_valid}, 1);
    chk("collide word", temp_word, 32'h30);
    chk("collide overrun", {31'b0, overrun}, 0);
    do_reset();
    repeat (3) send(8'h55);
    clkin = 0;
    repeat (120) @(negedge clock);
    chk("timeout fault", {31'b0, sensor_fault}, 1);
    chk("timeout valid", {31'b0, temp_valid}, 0);
    send(8'h20);
    chk("fault cleared", {31'b0, sensor_fault}, 0);
    repeat (7) send(8'h20);
    chk("post fault word", temp_word, 32'h20);
    chk("post fault valid", {31'b0, temp_valid}, 1);
    do_reset();
    repeat (5) send(8'h80);
    do_reset();
    repeat (8) send(8'h10);
    chk("midreset word", temp_word, 32'h10);
    chk("midreset overrun", {31'b0, overrun}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
